// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers weights and activations, then drives an NxN
// weight-stationary array.
// Ports: clk, reset; wr_en/wr_sel/wr_addr/wr_data host writes; start;
// load_weight, weight_out, a_out, valid_out to the array; busy, done.
module systolic_feeder #(
  parameter int N  = 2,
  parameter int M  = 2,
  parameter int DW = 8,
  localparam int MX = (N * N > M * N) ? N * N : M * N,
  localparam int AW = (MX > 1) ? $clog2(MX) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              start,
  output logic              load_weight,
  output logic [N*N*DW-1:0] weight_out,
  output logic [N*DW-1:0]   a_out,
  output logic [N-1:0]      valid_out,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(M + N + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    FIN
  } state_t;

  state_t state, state_n;
  logic ph, ph_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [DW-1:0] wbuf [N*N];
  logic [DW-1:0] abuf [M*N];
  logic [DW-1:0] wbuf_n [N*N];
  logic [DW-1:0] abuf_n [M*N];

  logic [N*N*DW-1:0] w_n;
  logic [N*DW-1:0] a_n;
  logic [N-1:0] v_n;

  // Next buffer contents; outputs are built from these so a write that
  // coincides with start is already visible in the run it launches.
  always_comb begin
    wbuf_n = wbuf;
    abuf_n = abuf;
    if (wr_en && state == IDLE) begin
      if (!wr_sel) begin
        if (int'(wr_addr) < N * N)
          wbuf_n[wr_addr] = wr_data;
      end else begin
        if (int'(wr_addr) < M * N)
          abuf_n[wr_addr] = wr_data;
      end
    end
  end

  // ph marks the second cycle of a beat; counters advance on it only.
  always_comb begin
    state_n = state;
    ph_n = ph;
    cnt_n = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD_W;
          ph_n = 1'b0;
          cnt_n = '0;
        end
      end
      LOAD_W: begin
        ph_n = ~ph;
        if (ph) begin
          state_n = STREAM;
          cnt_n = '0;
        end
      end
      STREAM: begin
        ph_n = ~ph;
        if (ph) begin
          if (cnt == CW'(M + N - 2)) begin
            state_n = DRAIN;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        ph_n = ~ph;
        if (ph) begin
          if (cnt == CW'(N - 1)) begin
            state_n = FIN;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      FIN: begin
        state_n = IDLE;
        ph_n = 1'b0;
        cnt_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Row r is active for beats r .. r+M-1 and carries act[(b-r)*N + r].
  always_comb begin
    w_n = '0;
    a_n = '0;
    v_n = '0;
    if (state_n != IDLE) begin
      for (int i = 0; i < N * N; i++)
        w_n[i*DW +: DW] = wbuf_n[i];
    end
    if (state_n == STREAM) begin
      for (int r = 0; r < N; r++) begin
        if (int'(cnt_n) >= r && int'(cnt_n) < r + M) begin
          v_n[r] = 1'b1;
          a_n[r*DW +: DW] = abuf_n[AW'((int'(cnt_n) - r) * N + r)];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ph <= 1'b0;
      cnt <= '0;
      for (int i = 0; i < N * N; i++)
        wbuf[i] <= '0;
      for (int i = 0; i < M * N; i++)
        abuf[i] <= '0;
      load_weight <= 1'b0;
      weight_out <= '0;
      a_out <= '0;
      valid_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      ph <= ph_n;
      cnt <= cnt_n;
      wbuf <= wbuf_n;
      abuf <= abuf_n;
      load_weight <= (state_n == LOAD_W);
      weight_out <= w_n;
      a_out <= a_n;
      valid_out <= v_n;
      busy <= (state_n != IDLE);
      done <= (state_n == FIN);
    end
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit-side driver for an N x N weight-stationary systolic array of PEs.
- Holds a weight matrix and M activation vectors in internal register buffers, loaded by a host write port.
- On start, broadcasts per-PE weights with load_weight, then streams row-skewed activations with per-row valid, paced to the PE's 2-cycle IDLE->LOAD/COMPUTE->IDLE cadence.
- Sits between the host/controller and the left edge plus weight inputs of the array.

Parameters:
N, 2, array dimension (rows = columns)
M, 2, activation vectors per run
DW, 8, data width
AW, $clog2(max(N*N, M*N)) (localparam), write address width

Ports:
clk  in  1  clock
reset  in  1  reset
wr_en  in  1  buffer write strobe
wr_sel  in  1  0 = weight buffer, 1 = activation buffer
wr_addr  in  AW  weight: r*N+c; activation: m*N+r (vector m, element for row r)
wr_data  in  DW  write data
start  in  1  begin a run (single-cycle pulse)
load_weight  out  1  to all PEs
weight_out  out  N*N*DW  PE(r,c) weight at slice (r*N+c)*DW
a_out  out  N*DW  activation to row r, slice r*DW
valid_out  out  N  per-row valid to the left-column PE
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- Reset clears both buffers, state = IDLE, and all outputs to 0. Reset mid-run aborts immediately: no done pulse, and outputs are 0 on the next cycle.
- Writes are accepted only in IDLE; writes while busy are dropped. An out-of-range wr_addr is dropped.
- Beat = 2 clock cycles. All beat outputs are held constant for both cycles of the beat.
  - This matches the PE protocol: the PE samples the control in IDLE and uses the data in the following cycle.
- State machine:
  - IDLE: outputs 0. start=1 goes to LOAD_W; start while busy is ignored.
  - LOAD_W: exactly 2 cycles. load_weight=1; weight_out = weight buffer. Then go to STREAM.
    - load_weight must not exceed 2 cycles, otherwise a PE reloads.
  - STREAM: M+N-1 beats, beat counter b = 0..M+N-2.
    - Row r with r <= b < r+M: valid_out[r]=1, a_out[r] = act[(b-r)*N + r].
    - Otherwise valid_out[r]=0 and a_out[r]=0.
    - load_weight=0; weight_out holds the buffer value.
  - DRAIN: N beats with all valid_out=0, letting partial sums exit the bottom row.
  - DONE: 1 cycle with done=1, then IDLE.
- busy=1 in LOAD_W, STREAM, DRAIN and DONE.
- Total run length after the start edge: 2 + 2(M+N-1) + 2N + 1 cycles.
- start in the same cycle as wr_en while IDLE: the write lands and the run starts; the run uses the newly written value.
- start during the DONE cycle is ignored.
- Outputs are registered. Counters wrap only via explicit reset at phase boundaries; no arithmetic is performed on data.

Test Plan:
- Reset: assert reset mid-STREAM -> next cycle busy=0, valid_out=0, a_out=0, load_weight=0; no done; a re-read run uses zeroed buffers.
- Weight load (N=2): write W=[[1,2],[3,4]], start at cycle 0 -> load_weight=1 for exactly cycles 1-2; weight_out slices = 1,2,3,4 from cycle 1 onward.
- Skewed stream (N=2, M=2): acts vec0=[5,6], vec1=[7,8].
  - Row0: cycles 3-4 a=5 v=1; cycles 5-6 a=7 v=1; cycles 7-8 v=0.
  - Row1: cycles 3-4 v=0; cycles 5-6 a=6 v=1; cycles 7-8 a=8 v=1.
- Completion: same run -> valid_out=0 for cycles 9-12; done=1 only at cycle 13; busy=1 for cycles 1-13 and 0 at cycle 14.
- Busy guards: during STREAM, wr_en to weight addr 0 with data 99 and a start pulse -> run timing unchanged; a second run later still shows weight 1 at slice 0.
- Simultaneous: in IDLE, write act addr 0 = 42 together with start -> row0 a_out=42 in cycles 3-4.
